// File: rtl/ddr3_rom_traffic_gen.sv
// Walks the 32-word pattern ROM, writes every word through the MIG app port,
// then reads each location back and scores it against the same ROM word.
module ddr3_rom_traffic_gen #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_STRIDE = 8,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  init_calib_complete,
  output logic [4:0]            rom_addr,
  input  logic [511:0]          rom_data,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [511:0]          app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [511:0]          app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [5:0]            err_count,
  output logic [4:0]            first_err_idx
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_FETCH = 3'd1;
  localparam logic [2:0] S_W_XFER  = 3'd2;
  localparam logic [2:0] S_R_FETCH = 3'd3;
  localparam logic [2:0] S_R_CMD   = 3'd4;
  localparam logic [2:0] S_R_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [4:0]            idx_reg;
  logic                  cmd_done_reg;
  logic                  data_done_reg;
  logic [TW-1:0]         tmo_reg;
  logic [ADDR_WIDTH-1:0] addr_calc;

  logic cmd_acc;
  logic data_acc;
  logic write_both;
  logic tmo_hit;
  logic rd_end;
  logic rd_bad;

  assign rom_addr     = idx_reg;
  assign app_wdf_data = (state_reg == S_W_XFER) ? rom_data : '0;
  assign addr_calc    = ADDR_WIDTH'(BASE_ADDR)
                      + ADDR_WIDTH'(idx_reg) * ADDR_WIDTH'(ADDR_STRIDE);

  // Command and data handshakes complete independently; a write ends once both have.
  always_comb begin
    cmd_acc    = app_en & app_rdy;
    data_acc   = app_wdf_wren & app_wdf_rdy;
    write_both = (cmd_done_reg | cmd_acc) & (data_done_reg | data_acc);
    tmo_hit    = (tmo_reg == TMO_LAST);
    rd_end     = app_rd_data_valid | tmo_hit;
    rd_bad     = app_rd_data_valid ? (app_rd_data != rom_data) : 1'b1;
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start && init_calib_complete) state_next = S_W_FETCH;
      S_W_FETCH: state_next = S_W_XFER;
      S_W_XFER:  if (write_both) state_next = (idx_reg == 5'd31) ? S_R_FETCH : S_W_FETCH;
      S_R_FETCH: state_next = S_R_CMD;
      S_R_CMD:   if (cmd_acc) state_next = S_R_WAIT;
      S_R_WAIT:  if (rd_end) state_next = (idx_reg == 5'd31) ? S_DONE : S_R_FETCH;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      cmd_done_reg  <= 1'b0;
      data_done_reg <= 1'b0;
      tmo_reg       <= '0;
      app_addr      <= ADDR_WIDTH'(BASE_ADDR);
      app_cmd       <= CMD_WRITE;
      app_en        <= 1'b0;
      app_wdf_wren  <= 1'b0;
      app_wdf_end   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != S_IDLE) && (state_next != S_DONE);
      app_addr  <= addr_calc;
      case (state_reg)
        S_IDLE: begin
          if (start && init_calib_complete) begin
            idx_reg       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
          end
        end
        S_W_FETCH: begin
          app_en        <= 1'b1;
          app_cmd       <= CMD_WRITE;
          app_wdf_wren  <= 1'b1;
          app_wdf_end   <= 1'b1;
          cmd_done_reg  <= 1'b0;
          data_done_reg <= 1'b0;
        end
        S_W_XFER: begin
          if (cmd_acc) begin
            app_en       <= 1'b0;
            cmd_done_reg <= 1'b1;
          end
          if (data_acc) begin
            app_wdf_wren  <= 1'b0;
            app_wdf_end   <= 1'b0;
            data_done_reg <= 1'b1;
          end
          // idx wraps 31 -> 0 naturally, which is the read phase start index
          if (write_both) idx_reg <= idx_reg + 5'd1;
        end
        S_R_FETCH: begin
          app_en  <= 1'b1;
          app_cmd <= CMD_READ;
        end
        S_R_CMD: begin
          if (cmd_acc) app_en <= 1'b0;
          tmo_reg <= '0;
        end
        S_R_WAIT: begin
          if (rd_end) begin
            if (rd_bad) begin
              err_count <= err_count + 6'd1;
              if (err_count == 6'd0) first_err_idx <= idx_reg;
            end
            idx_reg <= idx_reg + 5'd1;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        S_DONE: begin
          done <= 1'b1;
          pass <= (err_count == 6'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_rom_traffic_gen.sv
// Scoreboarded bench: a memory model behind the app port checks every write/read
// against queued expectations while directed runs exercise stalls, errors and reset.
module tb_ddr3_rom_traffic_gen;
  localparam int AW     = 28;
  localparam int TMO    = 15;
  localparam int RD_LAT = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          init_calib_complete = 1'b1;
  logic [4:0]    rom_addr;
  logic [511:0]  rom_data;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy = 1'b1;
  logic [511:0]  app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy = 1'b1;
  logic [511:0]  app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [5:0]    err_count;
  logic [4:0]    first_err_idx;

  ddr3_rom_traffic_gen #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .ADDR_STRIDE(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .init_calib_complete(init_calib_complete),
    .rom_addr(rom_addr), .rom_data(rom_data), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rom_word(input int i);
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'hC0DE_0000 + 32'(i * 256 + k);
    return w;
  endfunction

  always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [511:0]  mem [32];
  logic [AW-1:0] exp_waddr[$];
  logic [511:0]  exp_wdata[$];
  logic [AW-1:0] exp_raddr[$];
  logic [AW-1:0] got_waddr[$];
  logic [511:0]  got_wdata[$];
  logic [31:0]   corrupt_mask = '0;
  logic [31:0]   drop_mask = '0;
  int wr_seen = 0, rd_seen = 0, cyc = 0, busy_rise_cyc = 0, last_wacc_cyc = 0;
  int en5_cnt = 0, wren5_cnt = 0;
  int rd_cyc [32];
  int rd_timer = 0;
  logic [511:0] rd_buf = '0;
  logic busy_prev = 1'b0;

  // Memory model and monitor: samples handshakes on the falling edge.
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      rd_cyc[i] = 0;
    end
    forever begin
      logic [AW-1:0] a, ea;
      logic [511:0] d, ed;
      int wi;
      @(negedge clk);
      cyc++;
      app_rd_data_valid = 1'b0;
      if (!reset) begin
        rd_timer = 0;
        got_waddr.delete();
        got_wdata.delete();
        busy_prev = 1'b0;
      end else begin
        if (rd_timer > 0) begin
          rd_timer--;
          if (rd_timer == 0) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = rd_buf;
          end
        end
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy;
        if (app_en && app_cmd == 3'b000 && app_addr == AW'(40)) en5_cnt++;
        if (app_wdf_wren && app_addr == AW'(40)) wren5_cnt++;
        if (app_en && app_rdy) begin
          if (app_cmd == 3'b000) begin
            got_waddr.push_back(app_addr);
          end else if (app_cmd == 3'b001) begin
            wi = int'(app_addr >> 3) & 31;
            rd_seen++;
            rd_cyc[wi] = cyc;
            if (exp_raddr.size() == 0) begin
              n_checks++; n_errors++;
              $display("FAIL unexpected_read: addr %0h, no read expected", app_addr);
            end else begin
              ea = exp_raddr.pop_front();
              chk("rd_addr", 64'(app_addr), 64'(ea));
            end
            if (!drop_mask[wi]) begin
              rd_buf = mem[wi];
              if (corrupt_mask[wi]) rd_buf[0] = ~rd_buf[0];
              rd_timer = RD_LAT;
            end
          end else begin
            chk("app_cmd_legal", 64'(app_cmd), 64'(1));
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          chk("wdf_end", 64'(app_wdf_end), 64'(1));
          got_wdata.push_back(app_wdf_data);
          last_wacc_cyc = cyc;
        end
        while (got_waddr.size() > 0 && got_wdata.size() > 0) begin
          a = got_waddr.pop_front();
          d = got_wdata.pop_front();
          wr_seen++;
          if (exp_waddr.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_write: addr %0h, no write expected", a);
          end else begin
            ea = exp_waddr.pop_front();
            ed = exp_wdata.pop_front();
            chk("wr_addr", 64'(a), 64'(ea));
            chk_wide("wr_data", d, ed);
          end
          mem[int'(a >> 3) & 31] = d;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect;
    for (int i = 0; i < 32; i++) begin
      exp_waddr.push_back(AW'(i * 8));
      exp_wdata.push_back(rom_word(i));
      exp_raddr.push_back(AW'(i * 8));
    end
  endtask

  task automatic kick;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic run(input logic [31:0] cmask, input logic [31:0] dmask, input bit stall,
                     input bit meas_phase, input int exp_err, input int exp_first);
    int n;
    corrupt_mask = cmask;
    drop_mask = dmask;
    wr_seen = 0; rd_seen = 0; en5_cnt = 0; wren5_cnt = 0;
    push_expect();
    kick();
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_done_clr", 64'(done), 64'(0));
    chk("start_err_clr", 64'(err_count), 64'(0));
    chk("start_first_clr", 64'(first_err_idx), 64'(0));
    if (stall) begin
      n = 0;
      while (!(app_en && app_cmd == 3'b000 && app_addr == AW'(40)) && n < 500) begin
        tick;
        n++;
      end
      chk("stall_point_reached", 64'(n < 500), 64'(1));
      app_wdf_rdy = 1'b0;
      repeat (3) tick;
      app_wdf_rdy = 1'b1;
    end
    n = 0;
    while (!done && n < 5000) begin
      tick;
      n++;
    end
    chk("done_reached", 64'(done), 64'(1));
    chk("end_busy", 64'(busy), 64'(0));
    chk("err_count", 64'(err_count), 64'(exp_err));
    chk("first_err_idx", 64'(first_err_idx), 64'(exp_first));
    chk("pass", 64'(pass), 64'(exp_err == 0));
    chk("writes_seen", 64'(wr_seen), 64'(32));
    chk("reads_seen", 64'(rd_seen), 64'(32));
    chk("wr_queue_empty", 64'(exp_waddr.size()), 64'(0));
    chk("rd_queue_empty", 64'(exp_raddr.size()), 64'(0));
    if (meas_phase) chk("write_phase_cycles", 64'(last_wacc_cyc - busy_rise_cyc + 1), 64'(64));
    if (stall) begin
      chk("idx5_cmd_strobe_cycles", 64'(en5_cnt), 64'(1));
      chk("idx5_data_strobe_cycles", 64'(wren5_cnt), 64'(4));
    end
    if (dmask[3]) chk("timeout_read_gap", 64'(rd_cyc[4] - rd_cyc[3]), 64'(TMO + 2));
    tick;
    $display("run: corrupt=%08h drop=%08h stall=%0d err_count=%0d first_err_idx=%0d pass=%0d",
             cmask, dmask, stall, err_count, first_err_idx, pass);
  endtask

  initial begin
    int n;
    tick;
    chk("rst_app_en", 64'(app_en), 64'(0));
    chk("rst_wdf_wren", 64'(app_wdf_wren), 64'(0));
    chk("rst_wdf_end", 64'(app_wdf_end), 64'(0));
    chk("rst_app_cmd", 64'(app_cmd), 64'(0));
    chk("rst_app_addr", 64'(app_addr), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk_wide("rst_wdf_data", app_wdf_data, '0);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_first_err_idx", 64'(first_err_idx), 64'(0));
    tick;
    reset = 1'b1;
    tick;

    run(32'h0, 32'h0, 1'b0, 1'b1, 0, 0);
    run(32'h0, 32'h0, 1'b1, 1'b0, 0, 0);
    run(32'h0010_0080, 32'h0, 1'b0, 1'b0, 2, 7);
    run(32'h0, 32'h0000_0008, 1'b0, 1'b0, 1, 3);

    init_calib_complete = 1'b0;
    start = 1'b1;
    repeat (5) tick;
    chk("nocal_busy", 64'(busy), 64'(0));
    chk("nocal_app_en", 64'(app_en), 64'(0));
    start = 1'b0;
    init_calib_complete = 1'b1;
    tick;
    $display("calib-low start: busy=%0d app_en=%0d", busy, app_en);

    corrupt_mask = '0;
    drop_mask = '0;
    wr_seen = 0;
    push_expect();
    kick();
    n = 0;
    while (!(app_en && app_cmd == 3'b000 && app_addr == AW'(96)) && n < 500) begin
      tick;
      n++;
    end
    chk("idx12_reached", 64'(n < 500), 64'(1));
    reset = 1'b0;
    tick;
    chk("midrst_app_en", 64'(app_en), 64'(0));
    chk("midrst_wdf_wren", 64'(app_wdf_wren), 64'(0));
    chk("midrst_wdf_end", 64'(app_wdf_end), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_idx", 64'(rom_addr), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    reset = 1'b1;
    exp_waddr.delete();
    exp_wdata.delete();
    exp_raddr.delete();
    chk("midrst_writes_before", 64'(wr_seen), 64'(12));
    repeat (4) tick;
    chk("after_rst_idle", 64'(busy), 64'(0));
    $display("mid-run reset: writes_completed=%0d busy=%0d", wr_seen, busy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
